adsr_envelope_ctrl: RTL and testbench
=====================================

Name: adsr_envelope_ctrl

Overview:
Sequences the amplitude datapath from the keypad's 8-bit ADSR code (attack, decay, sustain and release, 2 bits each) and a note gate. It runs an ADSR state machine and steps an amplitude level once per sample tick. Sits between the keypad decoder's amp_envelope output and the output-stage multiplier, which scales the waveform sample by level.

Parameters:
AMP_W, 8, width of the level output; must be even and >= 8
MAX_LEVEL, 2**AMP_W-1, attack peak and saturation value

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
tick  input  1  sample-rate strobe, one clk wide; all state/level updates occur only on tick
gate  input  1  note held (1) / released (0), level-sensitive
retrig  input  1  one-clk pulse, restart attack from zero (see Optional Feature)
amp_envelope  input  8  [1:0]=A rate, [3:2]=D rate, [5:4]=S level, [7:6]=R rate; read live on each tick
level  output  AMP_W  current envelope amplitude, registered
env_state  output  3  0=IDLE 1=ATTACK 2=DECAY 3=SUSTAIN 4=RELEASE
busy  output  1  env_state != IDLE, registered

Behaviour:
- Reset (async assert, sync release): level=0, env_state=IDLE, busy=0. Reset asserted mid-envelope clears immediately, with no release tail.
- No tick: all registers hold, regardless of gate/amp_envelope changes.
- Rate step for code c: step = 1 << (2*c), giving 1, 4, 16, 64.
- Sustain target: S code replicated AMP_W/2 times, giving 0, 0x55, 0xAA, 0xFF for AMP_W=8.
- Arithmetic: use AMP_W+1 bits; clamp, never wrap.
- Outputs update on the clk edge where tick=1 (1-cycle latency from tick).
- On each tick, gate-driven transitions are evaluated first, with priority:
  - gate=1 and state IDLE or RELEASE -> ATTACK; level held this tick (attack continues from current level).
  - gate=0 and state ATTACK, DECAY or SUSTAIN -> RELEASE; level held this tick.
- Otherwise, per-state arithmetic:
  - IDLE: level=0.
  - ATTACK: level += A step; if the sum >= MAX_LEVEL, level=MAX_LEVEL and state -> DECAY.
  - DECAY: level -= D step; if the result <= target or underflows, level=target and state -> SUSTAIN. When target=MAX_LEVEL, the first DECAY tick enters SUSTAIN at MAX_LEVEL.
  - SUSTAIN: level = target, tracking live S changes; state unchanged.
  - RELEASE: level -= R step; if the result <= 0 or underflows, level=0 and state -> IDLE.
- Illegal env_state encodings (5-7) recover to IDLE with level=0 on the next tick.

Optional Feature:
ADSR_RETRIG_EN
- Defined: retrig is latched as pending until the next tick. On that tick, if gate=1, level=0 and state=ATTACK, with priority over all other rules. If gate=0 on that tick, the pending retrig is discarded.
- Undefined: the retrig port exists but is ignored (no pending register); a new note while gate stays high does not restart the envelope.

Test Plan:
- Reset with gate=1 and tick pulsing -> level=0, env_state=0, busy=0 throughout; after release, the first tick gives ATTACK with level=0.
- amp_envelope=8'b01_10_00_11, gate=1, tick every 4 clk:
  - tick1: ATTACK, level 0.
  - ticks 2-5: level 64, 128, 192, 255; DECAY at tick5.
  - Decay steps 1 per tick; tick 90 gives SUSTAIN at level 170.
  - gate=0: next tick RELEASE at 170; level then falls 4 per tick, reaching 0/IDLE 43 ticks later.
- Same config, gate dropped at level 128 in ATTACK -> next tick RELEASE at level 128; then 124, 120, ... down to 0; gate=1 re-asserted at level 60 -> ATTACK resumes from 60.
- S code=3 -> ATTACK reaches 255; next tick SUSTAIN at 255; changing S to 1 while in SUSTAIN -> level 0x55 on the next tick.
- tick held 0 for 1000 clk while gate and amp_envelope toggle -> level/env_state unchanged; rst_n pulsed low mid-DECAY -> level=0, IDLE within the same cycle, without waiting for a tick.
- ADSR_RETRIG_EN defined, SUSTAIN at 170, retrig pulse with gate=1 -> next tick ATTACK, level=0; same stimulus with the macro undefined -> stays SUSTAIN at 170.

Source files
------------

// File: rtl/adsr_envelope_ctrl.sv
`timescale 1ns/1ps
// ADSR envelope controller: steps an amplitude level once per sample tick from a packed 8-bit ADSR code.
// Optional feature macro ADSR_RETRIG_EN: retrig is held pending until the next tick and restarts the attack from zero.
module adsr_envelope_ctrl #(
    parameter int AMP_W     = 8,
    parameter int MAX_LEVEL = 2**AMP_W - 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             gate,
    input  logic             retrig,
    input  logic [7:0]       amp_envelope,
    output logic [AMP_W-1:0] level,
    output logic [2:0]       env_state,
    output logic             busy
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } state_e;

    localparam logic [AMP_W:0] MAX_W = (AMP_W+1)'(MAX_LEVEL);

    state_e           state_q, state_d;
    logic [AMP_W-1:0] level_q, level_d;
    logic             busy_q;
    logic             restart;

    // One extra bit of headroom so sums saturate and differences expose underflow in the MSB.
    logic [AMP_W:0] a_step, d_step, r_step, target_w, sum_w, dec_w, rel_w;

    assign a_step   = (AMP_W+1)'(1) << {amp_envelope[1:0], 1'b0};
    assign d_step   = (AMP_W+1)'(1) << {amp_envelope[3:2], 1'b0};
    assign r_step   = (AMP_W+1)'(1) << {amp_envelope[7:6], 1'b0};
    assign target_w = {1'b0, {(AMP_W/2){amp_envelope[5:4]}}};
    assign sum_w    = {1'b0, level_q} + a_step;
    assign dec_w    = {1'b0, level_q} - d_step;
    assign rel_w    = {1'b0, level_q} - r_step;

`ifdef ADSR_RETRIG_EN
    logic pend_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      pend_q <= 1'b0;
        else if (tick)   pend_q <= 1'b0;
        else if (retrig) pend_q <= 1'b1;
    end

    assign restart = (pend_q | retrig) & gate;
`else
    logic unused_retrig;
    assign unused_retrig = retrig;
    assign restart       = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            level_q <= '0;
            busy_q  <= 1'b0;
        end else if (tick) begin
            state_q <= state_d;
            level_q <= level_d;
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns state_d/level_d and no latch is inferred.
        state_d = state_q;
        level_d = level_q;
        if (restart) begin
            state_d = ST_ATTACK;
            level_d = '0;
        end else if (gate && (state_q == ST_IDLE || state_q == ST_RELEASE)) begin
            state_d = ST_ATTACK;
        end else if (!gate && (state_q == ST_ATTACK || state_q == ST_DECAY || state_q == ST_SUSTAIN)) begin
            state_d = ST_RELEASE;
        end else begin
            case (state_q)
                ST_IDLE: level_d = '0;
                ST_ATTACK: begin
                    if (sum_w >= MAX_W) begin
                        level_d = MAX_W[AMP_W-1:0];
                        state_d = ST_DECAY;
                    end else begin
                        level_d = sum_w[AMP_W-1:0];
                    end
                end
                ST_DECAY: begin
                    if (dec_w[AMP_W] || dec_w <= target_w) begin
                        level_d = target_w[AMP_W-1:0];
                        state_d = ST_SUSTAIN;
                    end else begin
                        level_d = dec_w[AMP_W-1:0];
                    end
                end
                ST_SUSTAIN: level_d = target_w[AMP_W-1:0];
                ST_RELEASE: begin
                    if (rel_w[AMP_W] || rel_w == '0) begin
                        level_d = '0;
                        state_d = ST_IDLE;
                    end else begin
                        level_d = rel_w[AMP_W-1:0];
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    level_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        level     = level_q;
        env_state = state_q;
        busy      = busy_q;
    end

endmodule

// File: tb/tb_adsr_envelope_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for adsr_envelope_ctrl: an integer reference model feeds a scoreboard on every tick.
module tb_adsr_envelope_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic       gate;
    logic       retrig;
    logic [7:0] amp_envelope;
    logic [7:0] level;
    logic [2:0] env_state;
    logic       busy;

    adsr_envelope_ctrl #(.AMP_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick         (tick),
        .gate         (gate),
        .retrig       (retrig),
        .amp_envelope (amp_envelope),
        .level        (level),
        .env_state    (env_state),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic [7:0] lvl;
        logic       bsy;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_state;
    int   m_level;
    bit   m_pend;

    localparam logic [7:0] CFG_A = 8'b01_10_00_11;
    localparam logic [7:0] CFG_S3 = 8'b01_11_00_11;
    localparam logic [7:0] CFG_S1 = 8'b01_01_00_11;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        int a_st, d_st, r_st, tgt;
        a_st = 1 << (2 * amp_envelope[1:0]);
        d_st = 1 << (2 * amp_envelope[3:2]);
        r_st = 1 << (2 * amp_envelope[7:6]);
        tgt  = 85 * amp_envelope[5:4];
        if (m_pend && gate) begin
            m_state = 1;
            m_level = 0;
        end else if (gate && (m_state == 0 || m_state == 4)) begin
            m_state = 1;
        end else if (!gate && m_state >= 1 && m_state <= 3) begin
            m_state = 4;
        end else begin
            case (m_state)
                0: m_level = 0;
                1: begin
                    m_level += a_st;
                    if (m_level >= 255) begin m_level = 255; m_state = 2; end
                end
                2: begin
                    m_level -= d_st;
                    if (m_level <= tgt) begin m_level = tgt; m_state = 3; end
                end
                3: m_level = tgt;
                4: begin
                    m_level -= r_st;
                    if (m_level <= 0) begin m_level = 0; m_state = 0; end
                end
                default: begin m_level = 0; m_state = 0; end
            endcase
        end
        m_pend = 1'b0;
    endtask

    task automatic do_tick(input string tag);
        exp_t e;
        @(negedge clk);
        tick = 1'b1;
        model_step();
        e.st  = m_state[2:0];
        e.lvl = m_level[7:0];
        e.bsy = (m_state != 0);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        tick = 1'b0;
        e = sb_q.pop_front();
        check({tag, "_state"}, env_state, e.st);
        check({tag, "_level"}, level, e.lvl);
        check({tag, "_busy"}, busy, e.bsy);
    endtask

    task automatic check_const(input string tag, input int st, input int lvl);
        check({tag, "_state"}, env_state, st);
        check({tag, "_level"}, level, lvl);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        tick   = 1'b0;
        retrig = 1'b0;
        rst_n  = 1'b0;
        #1;
        check_const("rst", 0, 0);
        check("rst_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        m_state = 0;
        m_level = 0;
        m_pend  = 1'b0;
        sb_q.delete();
    endtask

    task automatic pulse_retrig();
        @(negedge clk);
        retrig = 1'b1;
`ifdef ADSR_RETRIG_EN
        m_pend = 1'b1;
`endif
        @(negedge clk);
        retrig = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b0;
        tick         = 1'b0;
        gate         = 1'b1;
        retrig       = 1'b0;
        amp_envelope = CFG_A;
        m_state      = 0;
        m_level      = 0;
        m_pend       = 1'b0;

        // Reset held while tick pulses with gate high: outputs stay cleared.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tick = 1'b1;
            @(posedge clk);
            #1;
            tick = 1'b0;
            check_const("hold_rst", 0, 0);
            check("hold_rst_busy", busy, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Full envelope: attack by 64, decay by 1 to 0xAA, release by 4.
        for (int t = 1; t <= 90; t++) begin
            do_tick("env");
            if (t == 1)  check_const("t1", 1, 0);
            if (t == 5)  check_const("t5", 2, 255);
            if (t == 90) check_const("t90", 3, 170);
        end
        gate = 1'b0;
        do_tick("rel");
        check_const("rel_first", 4, 170);
        for (int t = 1; t <= 43; t++) begin
            do_tick("rel");
            if (t == 42) check_const("rel42", 4, 2);
            if (t == 43) check_const("rel43", 0, 0);
        end

        // Gate dropped mid-attack, then re-asserted during release.
        gate = 1'b1;
        apply_reset();
        repeat (3) do_tick("atk");
        check_const("atk128", 1, 128);
        gate = 1'b0;
        do_tick("drop");
        check_const("drop", 4, 128);
        repeat (17) do_tick("fall");
        check_const("fall60", 4, 60);
        gate = 1'b1;
        do_tick("resume");
        check_const("resume", 1, 60);
        do_tick("resume2");
        check_const("resume2", 1, 124);

        // Sustain at full scale, then live S change.
        amp_envelope = CFG_S3;
        apply_reset();
        repeat (5) do_tick("s3");
        check_const("s3_peak", 2, 255);
        do_tick("s3_sus");
        check_const("s3_sus", 3, 255);
        amp_envelope = CFG_S1;
        do_tick("s1_sus");
        check_const("s1_sus", 3, 85);

        // No tick for 1000 clocks while inputs wander: nothing moves.
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            gate         = 1'($urandom_range(0, 1));
            amp_envelope = 8'($urandom_range(0, 255));
        end
        #1;
        check("notick_state", env_state, m_state);
        check("notick_level", level, m_level);
        check("notick_busy", busy, 1);

        // Asynchronous reset in the middle of decay.
        gate         = 1'b1;
        amp_envelope = CFG_A;
        apply_reset();
        repeat (10) do_tick("pre_async");
        check_const("mid_decay", 2, 250);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_const("async_rst", 0, 0);
        check("async_rst_busy", busy, 0);
        @(negedge clk);
        rst_n   = 1'b1;
        m_state = 0;
        m_level = 0;

        // Retrigger from sustain, then a retrigger discarded because gate is low.
        repeat (90) do_tick("to_sus");
        check_const("sus170", 3, 170);
        pulse_retrig();
        do_tick("retrig");
`ifdef ADSR_RETRIG_EN
        check_const("retrig_on", 1, 0);
`else
        check_const("retrig_off", 3, 170);
`endif
        repeat (3) do_tick("post_retrig");
        pulse_retrig();
        gate = 1'b0;
        do_tick("discard");
        gate = 1'b1;
        do_tick("discard2");
        check("discard_busy", busy, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
